mant_mul_24_seq: RTL

Iterative 24x24 unsigned mantissa multiplier for the single-precision FPU multiply path. It sits directly downstream of the combinational `vedic_8x8` multiplier: it instantiates exactly one `vedic_8x8` and consumes its 16-bit partial products over nine cycles. It accumulates them into a 48-bit product that feeds the FP normalise/round stage. A start/busy/done handshake lets the FPU control FSM stall the pipeline while the product forms.

---
 rtl/mant_mul_24_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mant_mul_24_seq.sv
// rtl/mant_mul_24_seq.sv - iterative 24x24 mantissa multiplier built around one vedic_8x8

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t0, t1, t2, t3, c;

    always_comb begin
        t0   = a[0] & b[0];
        t1   = a[1] & b[0];
        t2   = a[0] & b[1];
        t3   = a[1] & b[1];
        c    = t1 & t2;
        p[0] = t0;
        p[1] = t1 ^ t2;
        p[2] = t3 ^ c;
        p[3] = t3 & c;
    end
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] p_ll, p_hl, p_lh, p_hh;
    logic [4:0] mid;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(p_ll));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(p_hl));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(p_lh));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(p_hh));

    always_comb begin
        mid = {1'b0, p_hl} + {1'b0, p_lh};
        p   = {4'b0, p_ll} + {1'b0, mid, 2'b0} + {p_hh, 4'b0};
    end
endmodule

module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] p_ll, p_hl, p_lh, p_hh;
    logic [8:0] mid;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(p_ll));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(p_hl));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(p_lh));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(p_hh));

    always_comb begin
        mid = {1'b0, p_hl} + {1'b0, p_lh};
        p   = {8'b0, p_ll} + {3'b0, mid, 4'b0} + {p_hh, 8'b0};
    end
endmodule

module mant_mul_24_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        busy,
    output logic        done,
    output logic [47:0] p
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] a_r_q, a_r_d, b_r_q, b_r_d;
    logic [47:0] acc_q, acc_d, p_q, p_d;
    logic [1:0]  ai_q, ai_d, bi_q, bi_d;

    logic [7:0]  a_byte, b_byte;
    logic [15:0] pp;
    logic [2:0]  byte_sh;
    logic [47:0] pp_sh;
    logic        accept, last_step;

    vedic_8x8 u_vedic (.a(a_byte), .b(b_byte), .p(pp));

    // Byte index 3 never occurs; the default arm keeps the select in range.
    always_comb begin
        case (ai_q)
            2'd0:    a_byte = a_r_q[7:0];
            2'd1:    a_byte = a_r_q[15:8];
            default: a_byte = a_r_q[23:16];
        endcase
        case (bi_q)
            2'd0:    b_byte = b_r_q[7:0];
            2'd1:    b_byte = b_r_q[15:8];
            default: b_byte = b_r_q[23:16];
        endcase
        byte_sh   = {1'b0, ai_q} + {1'b0, bi_q};
        pp_sh     = {32'b0, pp} << {byte_sh, 3'b000};
        accept    = start && (state_q != MUL);
        last_step = (state_q == MUL) && (ai_q == 2'd2) && (bi_q == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? MUL : IDLE;
            MUL:        state_d = last_step ? DONE : MUL;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MUL);
        done = (state_q == DONE);
        p    = p_q;
    end

    always_comb begin
        a_r_d = a_r_q;
        b_r_d = b_r_q;
        acc_d = acc_q;
        ai_d  = ai_q;
        bi_d  = bi_q;
        p_d   = p_q;
        if (accept) begin
            a_r_d = a;
            b_r_d = b;
            acc_d = '0;
            ai_d  = '0;
            bi_d  = '0;
        end else if (state_q == MUL) begin
            acc_d = acc_q + pp_sh;
            if (ai_q == 2'd2) begin
                ai_d = '0;
                bi_d = (bi_q == 2'd2) ? 2'd0 : bi_q + 2'd1;
            end else begin
                ai_d = ai_q + 2'd1;
            end
            if (last_step) begin
                p_d = acc_q + pp_sh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r_q <= '0;
            b_r_q <= '0;
            acc_q <= '0;
            ai_q  <= '0;
            bi_q  <= '0;
            p_q   <= '0;
        end else begin
            a_r_q <= a_r_d;
            b_r_q <= b_r_d;
            acc_q <= acc_d;
            ai_q  <= ai_d;
            bi_q  <= bi_d;
            p_q   <= p_d;
        end
    end
endmodule
